// File: rtl/clock_ctrl_pkg.sv
// Shared types and defaults for the clock-enable controller.
//   state_t         : FSM state encodings, also driven out on state_o
//   WIDTH_DEFAULT   : default width of the divide value / period counter
//   DIV_DEFAULT_VAL : default divide value loaded at reset (period = value+1)
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  localparam int WIDTH_DEFAULT   = 26;
  localparam int DIV_DEFAULT_VAL = 10;

endpackage

// File: rtl/tick_counter.sv
// Period counter for the clock-enable controller.
// Holds the divide register and the running count, and produces a registered
// one-cycle pulse every div_reg+1 enabled cycles.
// Ports:
//   f_in, rst_n : clock, async active-low reset
//   load        : capture div_val, clear count, suppress pulse (beats tick)
//   div_val     : new divide value
//   en          : count this cycle; when low the count is held at zero
//   fire        : comb, high in the cycle the pulse register will be set
//   pulse       : registered tick-enable pulse
module tick_counter
  import clock_ctrl_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int DIV_DEFAULT = DIV_DEFAULT_VAL
) (
  input  logic             f_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  input  logic             en,
  output logic             fire,
  output logic             pulse
);

  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] count;
  logic             tc;

  assign tc   = (count == div_reg);
  assign fire = en & tc & ~load;

  always_ff @(posedge f_in or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= WIDTH'(DIV_DEFAULT);
      count   <= '0;
      pulse   <= 1'b0;
    end else if (load) begin
      div_reg <= div_val;
      count   <= '0;
      pulse   <= 1'b0;
    end else if (fire) begin
      count   <= '0;
      pulse   <= 1'b1;
    end else if (en) begin
      count   <= count + 1'b1;
      pulse   <= 1'b0;
    end else begin
      // idle or leaving RUN/STEP: any partial period is dropped
      count   <= '0;
      pulse   <= 1'b0;
    end
  end

endmodule

// File: rtl/clock_enable_ctrl.sv
// Clock-enable controller: free-running or single-step tick-enable generator.
// Optional feature: define CLOCK_CTRL_STEP_EN to build single-step support
// (step edge detect and STEP state). Without it, step is ignored.
// Ports:
//   f_in, rst_n : system clock, async active-low reset
//   div_val     : new divide value, captured on div_load
//   div_load    : one-cycle strobe; reload divider, restart period, state held
//   run         : level, free-running request
//   halt        : level, forces IDLE, highest priority
//   step        : debounced level; rising edge requests one tick
//   f_out       : registered one-cycle tick-enable pulse
//   state_o     : 00 IDLE, 01 RUN, 10 STEP
//   tick_cnt    : number of f_out pulses issued, wraps
module clock_enable_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEFAULT,
  parameter int DIV_DEFAULT = DIV_DEFAULT_VAL
) (
  input  logic             f_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  input  logic             run,
  input  logic             halt,
  input  logic             step,
  output logic             f_out,
  output logic [1:0]       state_o,
  output logic [15:0]      tick_cnt
);

  state_t state, state_nxt;
  logic   cnt_en;
  logic   fire;
  logic   step_edge;

`ifdef CLOCK_CTRL_STEP_EN
  logic step_q;

  always_ff @(posedge f_in or negedge rst_n) begin
    if (!rst_n) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_edge = step & ~step_q;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_edge   = 1'b0;
`endif

  always_ff @(posedge f_in or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A divider load freezes the state for that cycle.
  always_comb begin
    state_nxt = state;
    if (!div_load) begin
      unique case (state)
        ST_IDLE: begin
          if (halt)           state_nxt = ST_IDLE;
          else if (run)       state_nxt = ST_RUN;   // run beats a same-cycle step edge
          else if (step_edge) state_nxt = ST_STEP;
        end
        ST_RUN:  if (halt || !run) state_nxt = ST_IDLE;
        ST_STEP: if (halt || fire) state_nxt = ST_IDLE; // leave with the single pulse
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Counting stops on the exit edge so no pulse is issued while leaving.
  always_comb begin
    cnt_en  = ((state == ST_RUN)  && run && !halt) ||
              ((state == ST_STEP) && !halt);
    state_o = state;
  end

  tick_counter #(
    .WIDTH       (WIDTH),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_tick_counter (
    .f_in    (f_in),
    .rst_n   (rst_n),
    .load    (div_load),
    .div_val (div_val),
    .en      (cnt_en),
    .fire    (fire),
    .pulse   (f_out)
  );

  always_ff @(posedge f_in or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (fire) tick_cnt <= tick_cnt + 16'd1;
  end

endmodule

// File: tb/tb_clock_enable_ctrl.sv
module tb_clock_enable_ctrl;

  logic        f_in = 1'b0;
  logic        rst_n;
  logic [25:0] div_val;
  logic        div_load, run, halt, step;
  logic        f_out;
  logic [1:0]  state_o;
  logic [15:0] tick_cnt;

  int total = 0;
  int bad   = 0;

  clock_enable_ctrl dut (
    .f_in     (f_in),
    .rst_n    (rst_n),
    .div_val  (div_val),
    .div_load (div_load),
    .run      (run),
    .halt     (halt),
    .step     (step),
    .f_out    (f_out),
    .state_o  (state_o),
    .tick_cnt (tick_cnt)
  );

  always #5 f_in = ~f_in;

  localparam logic [1:0] SI = 2'b00, SR = 2'b01, SS = 2'b10;

  // One record: hold inputs for n rising edges, then expect outputs.
  typedef struct {
    logic        run, halt, ld;
    logic [25:0] dv;
    logic        step;
    int          n;
    logic        ef;
    logic [1:0]  est;
    logic [15:0] etc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic h, logic l, logic [25:0] d, logic s,
                              int n, logic ef, logic [1:0] est, logic [15:0] etc);
    vec_t v;
    v.run = r; v.halt = h; v.ld = l; v.dv = d; v.step = s; v.n = n;
    v.ef = ef; v.est = est; v.etc = etc;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    int first;
    logic seen;

    rst_n = 1'b0; div_val = '0; div_load = 0; run = 0; halt = 0; step = 0;

    // ---- table: reset state, free run, divider loads, halt, run drop ----
    add(0,0,0, 0,0, 1, 0,SI, 0);   // reset state
    add(1,0,0, 0,0, 1, 0,SR, 0);   // entering edge
    add(1,0,0, 0,0,10, 0,SR, 0);   // count 1..10, no pulse yet
    add(1,0,0, 0,0, 1, 1,SR, 1);   // 11 cycles after entry
    add(1,0,0, 0,0,10, 0,SR, 1);
    add(1,0,0, 0,0, 1, 1,SR, 2);
    add(1,0,0, 0,0,10, 0,SR, 2);
    add(1,0,0, 0,0, 1, 1,SR, 3);
    add(1,0,1, 3,0, 1, 0,SR, 3);   // load 3, count cleared
    add(1,0,0, 0,0, 3, 0,SR, 3);
    add(1,0,0, 0,0, 1, 1,SR, 4);
    add(1,0,0, 0,0, 3, 0,SR, 4);
    add(1,0,0, 0,0, 1, 1,SR, 5);
    add(1,0,1, 0,0, 1, 0,SR, 5);   // load 0
    add(1,0,0, 0,0, 1, 1,SR, 6);
    add(1,0,0, 0,0, 5, 1,SR,11);   // high every cycle
    add(1,0,1,10,0, 1, 0,SR,11);
    add(1,0,0, 0,0, 5, 0,SR,11);   // count 5
    add(1,1,0, 0,0, 1, 0,SI,11);   // halt -> IDLE, no pulse
    add(1,1,0, 0,0, 3, 0,SI,11);   // run+halt stays IDLE
    add(0,0,0, 0,0,15, 0,SI,11);
    add(1,0,1,10,0, 1, 0,SI,11);   // load holds state even with run
    add(1,0,0, 0,0, 1, 0,SR,11);
    add(1,0,0, 0,0,10, 0,SR,11);   // count at terminal value
    add(1,0,1, 2,0, 1, 0,SR,11);   // load coincident with tick wins
    add(1,0,0, 0,0, 2, 0,SR,11);
    add(1,0,0, 0,0, 1, 1,SR,12);
    add(1,0,0, 0,0, 1, 0,SR,12);
    add(0,0,0, 0,0, 1, 0,SI,12);   // run low -> IDLE
    add(0,0,0, 0,0, 5, 0,SI,12);
`ifdef CLOCK_CTRL_STEP_EN
    add(0,0,1,10,0, 1, 0,SI,12);
    add(0,0,0, 0,1, 1, 0,SS,12);   // step edge enters STEP
    add(0,0,0, 0,1,10, 0,SS,12);
    add(0,0,0, 0,1, 1, 1,SI,13);   // single pulse, back to IDLE
    add(0,0,0, 0,1, 8, 0,SI,13);   // held high: no second pulse
    add(0,0,0, 0,0, 1, 0,SI,13);
    add(0,0,0, 0,1, 1, 0,SS,13);
    add(1,0,0, 0,1,10, 0,SS,13);   // run ignored in STEP
    add(1,0,0, 0,1, 1, 1,SI,14);
    add(1,0,0, 0,1, 1, 0,SR,14);
    add(0,0,0, 0,0, 1, 0,SI,14);
    add(1,0,0, 0,1, 1, 0,SR,14);   // run and step edge together -> RUN
    add(0,0,0, 0,1, 1, 0,SI,14);
    add(0,0,0, 0,1,15, 0,SI,14);   // discarded edge never replays
    add(0,0,0, 0,0, 1, 0,SI,14);
    add(0,0,0, 0,1, 1, 0,SS,14);
    add(0,0,0, 0,1, 4, 0,SS,14);
    add(0,1,0, 0,1, 1, 0,SI,14);   // halt aborts step
    add(0,0,0, 0,1,15, 0,SI,14);
`else
    for (int i = 0; i < 10; i++) add(0,0,0,0,1'(i & 1), 1, 0,SI,12);
    for (int i = 0; i < 6;  i++) add(0,0,0,0,1'(i & 1), 3, 0,SI,12);
`endif

    repeat (2) @(negedge f_in);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run = tbl[i].run; halt = tbl[i].halt; div_load = tbl[i].ld;
      div_val = tbl[i].dv; step = tbl[i].step;
      repeat (tbl[i].n) @(posedge f_in);
      @(negedge f_in);
      chk($sformatf("vec%0d {f_out,state,tick_cnt}", i),
          {13'd0, f_out, state_o, tick_cnt},
          {13'd0, tbl[i].ef, tbl[i].est, tbl[i].etc});
    end

    // ---- async reset while f_out is high, divider back to default ----
    run = 1; halt = 0; step = 0; div_load = 1; div_val = 0;
    @(posedge f_in); @(negedge f_in);
    div_load = 0;
    repeat (3) @(posedge f_in);
    @(negedge f_in);
    chk("pre_reset_f_out", {31'd0, f_out}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_f_out", {31'd0, f_out}, 32'd0);
    chk("async_rst_state", {30'd0, state_o}, 32'd0);
    chk("async_rst_tick_cnt", {16'd0, tick_cnt}, 32'd0);
    run = 0;
    @(negedge f_in); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge f_in);
      if (f_out || tick_cnt != 0 || state_o != SI) seen = 1;
    end
    chk("no_pulse_after_reset", {31'd0, seen}, 32'd0);
    run = 1; first = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge f_in); @(negedge f_in);
      if (f_out && first == 0) first = k;
    end
    chk("default_div_first_pulse_edge", first, 32'd12);
    run = 0;
    @(posedge f_in); @(negedge f_in);

`ifdef CLOCK_CTRL_STEP_EN
    // ---- reset mid-STEP at count 7 ----
    step = 1;
    repeat (8) @(posedge f_in);     // entry edge + 7 counting edges
    @(negedge f_in);
    chk("mid_step_state", {30'd0, state_o}, {30'd0, SS});
    #2 rst_n = 1'b0;
    #1;
    chk("step_rst_state", {30'd0, state_o}, 32'd0);
    chk("step_rst_f_out", {31'd0, f_out}, 32'd0);
    step = 0;
    @(negedge f_in); rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge f_in);
      if (f_out || state_o != SI) seen = 1;
    end
    chk("no_pulse_after_step_reset", {31'd0, seen}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clock_enable_ctrl.md
CLOCK_ENABLE_CTRL -- requirements
Module: clock_enable_ctrl

Interface
REQ-001 Parameter WIDTH, default 26, width of divide value and internal counter.
REQ-002 Parameter DIV_DEFAULT, default 10, divide value loaded at reset (period = DIV_DEFAULT+1 cycles).
REQ-003 f_in  input  1  system clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 div_val  input  WIDTH  new divide value.
REQ-006 div_load  input  1  single-cycle strobe; capture div_val.
REQ-007 run  input  1  level; request free-running tick generation.
REQ-008 halt  input  1  level; force stop, highest priority.
REQ-009 step  input  1  level from debounced button; rising edge requests one tick.
REQ-010 f_out  output  1  registered tick-enable pulse, one cycle wide.
REQ-011 state_o  output  2  current state: 00 IDLE, 01 RUN, 10 STEP.
REQ-012 tick_cnt  output  16  count of f_out pulses issued, wraps 0xFFFF->0x0000.

Function
REQ-013 Internal div_reg (WIDTH) and count (WIDTH); tick period = div_reg+1 cycles.
REQ-014 div_load high: div_reg <= div_val, count <= 0, f_out <= 0 that cycle, state unchanged.
REQ-015 div_val = 0 legal: f_out high every cycle while RUN.
REQ-016 IDLE: count held at 0, f_out 0; halt -> stay; run -> RUN; else step rising edge -> STEP.
REQ-017 run and step edge in same IDLE cycle -> RUN; step edge discarded.
REQ-018 RUN/STEP per cycle: count == div_reg -> count <= 0, f_out <= 1; else count <= count+1, f_out <= 0.
REQ-019 First f_out asserted exactly div_reg+1 cycles after edge entering RUN or STEP.
REQ-020 RUN: halt or run low -> IDLE next edge, count <= 0, f_out <= 0; step edges ignored.
REQ-021 STEP: after its single f_out pulse -> IDLE; halt aborts to IDLE with no pulse; run ignored until IDLE.
REQ-022 Step edge detect uses one registered copy of step; edge = step & ~step_q.
REQ-023 tick_cnt increments in the same cycle f_out is registered high.
REQ-024 div_load coincident with tick: load wins, no pulse.

Reset
REQ-025 rst_n low: state IDLE, count 0, div_reg DIV_DEFAULT, f_out 0, tick_cnt 0, step_q 0.
REQ-026 Reset mid-RUN or mid-STEP discards partial period; no pulse after release until a new run/step.
REQ-027 rst_n assertion immediate; deassertion used synchronously by the integrating top level.

Configuration
REQ-028 Macro CLOCK_CTRL_STEP_EN compiles in single-step support (step input, edge detect, STEP state).
REQ-029 Without CLOCK_CTRL_STEP_EN: step port present but ignored, STEP state unreachable, state_o never 10.

Structure
REQ-030 Package clock_ctrl_pkg: state typedef (IDLE/RUN/STEP encodings), WIDTH and DIV_DEFAULT default constants.
REQ-031 One sub-module tick_counter: count register, clear, load, terminal-count compare, registered pulse.
REQ-032 FSM, step edge detect, tick_cnt in clock_enable_ctrl.

Verification
REQ-033 Reset, run=1, defaults -> f_out pulses every 11 cycles, first on cycle 11; tick_cnt 1,2,3.
REQ-034 div_load div_val=3 during RUN -> count cleared, next pulses every 4 cycles; div_val=0 -> f_out constant 1.
REQ-035 IDLE, step 0->1 held 20 cycles, div=10 -> exactly one f_out after 11 cycles, state returns 00.
REQ-036 RUN, halt=1 at count 5 -> IDLE next edge, no pulse; run and halt both high -> remains IDLE.
REQ-037 rst_n low mid-STEP at count 7 -> all outputs 0 immediately, div_reg 10, no later pulse.
REQ-038 Build without CLOCK_CTRL_STEP_EN: step toggling -> no f_out, state_o stays 00.
